// File: rtl/shift_sub_divider_if.sv
// Operand/result bundle for the shift-subtract divider. The requester uses
// the master modport, and the divider uses the slave modport.
interface shift_sub_divider_if #(
  parameter int WIDTH = 4
);
  logic             Start;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Busy;
  logic             Done;
  logic             Div_By_Zero;

  modport master (
    output Start, Dividend, Divisor,
    input  Quotient, Remainder, Busy, Done, Div_By_Zero
  );

  modport slave (
    input  Start, Dividend, Divisor,
    output Quotient, Remainder, Busy, Done, Div_By_Zero
  );
endinterface

// File: rtl/shift_sub_divider.sv
// Unsigned restoring divider. It handles one quotient bit per clock, MSB first,
// and the latency is fixed at WIDTH steps. A zero divisor finishes at once.
module shift_sub_divider #(
  parameter int WIDTH = 4
) (
  input logic                Clk,
  input logic                Rst,
  shift_sub_divider_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd;        // dividend bits shift out; quotient bits shift in
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic             last_step;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] dvd_step;

  assign last_step = (count == CW'(WIDTH - 1));

  // The working partial remainder is one bit wider than the operands. This lets
  // the compare and the subtract see the bit shifted out of the top.
  assign shifted  = {rem, dvd[WIDTH-1]};
  assign fits     = (shifted >= {1'b0, dvs});
  assign rem_step = fits ? (shifted - {1'b0, dvs}) : shifted;
  assign dvd_step = {dvd[WIDTH-2:0], fits};

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.Start) state_next = (bus.Divisor == '0) ? DONE : RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all of these are flops, not a memory, so a synchronous clear is
  // cheap. The clear also gives the outputs a defined value after reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count       <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            dvd   <= bus.Dividend;
            dvs   <= bus.Divisor;
            rem   <= '0;
            count <= '0;
            if (bus.Divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= bus.Dividend;
              dbz_q       <= 1'b1;
            end
          end
        end
        RUN: begin
          rem   <= rem_step[WIDTH-1:0];
          dvd   <= dvd_step;
          count <= count + CW'(1);
          if (last_step) begin
            quotient_q  <= dvd_step;
            remainder_q <= rem_step[WIDTH-1:0];
            dbz_q       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy        = (state == RUN);
  assign bus.Done        = (state == DONE);
  assign bus.Quotient    = quotient_q;
  assign bus.Remainder   = remainder_q;
  assign bus.Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed bench for shift_sub_divider. It uses a vector table, abort/ignore
// sequences and a held-Start sweep over all operand pairs.
module tb_shift_sub_divider;

  localparam int W = 4;

  logic Clk = 1'b0;
  logic Rst;
  int   tests  = 0;
  int   failed = 0;

  shift_sub_divider_if #(.WIDTH(W)) bus ();

  shift_sub_divider #(.WIDTH(W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_dbz;
    int           exp_lat;
    int           exp_busy;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Start one division and wait for Done. Latency is counted in edges after
  // the accept edge. The operands are scrambled after that edge.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cnt);
    bus.Start    = 1'b1;
    bus.Dividend = a;
    bus.Divisor  = b;
    tick();
    bus.Start    = 1'b0;
    bus.Dividend = ~a;
    bus.Divisor  = b + 4'd5;
    lat      = 0;
    busy_cnt = 0;
    while (!bus.Done && lat < 20) begin
      if (bus.Busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, busy_cnt, done_cnt, gap;
    logic [W-1:0] cap_q, cap_r;
    logic first;

    vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, W, W};
    vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, W, W};
    vecs[2] = '{4'd3,  4'd9,  4'd0,  4'd3, 1'b0, W, W};
    vecs[3] = '{4'd7,  4'd0,  4'd15, 4'd7, 1'b1, 0, 0};
    vecs[4] = '{4'd12, 4'd5,  4'd2,  4'd2, 1'b0, W, W};
    vecs[5] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, W, W};
    vecs[6] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, W, W};
    vecs[7] = '{4'd8,  4'd2,  4'd4,  4'd0, 1'b0, W, W};
    vecs[8] = '{4'd0,  4'd0,  4'd15, 4'd0, 1'b1, 0, 0};

    bus.Start    = 1'b0;
    bus.Dividend = '0;
    bus.Divisor  = '0;
    Rst          = 1'b1;
    tick();
    tick();
    check("reset_quotient",  bus.Quotient,    0);
    check("reset_remainder", bus.Remainder,   0);
    check("reset_busy",      bus.Busy,        0);
    check("reset_done",      bus.Done,        0);
    check("reset_dbz",       bus.Div_By_Zero, 0);
    Rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_div(vecs[i].dividend, vecs[i].divisor, lat, busy_cnt);
      check($sformatf("vec%0d_latency", i),   lat,                 vecs[i].exp_lat);
      check($sformatf("vec%0d_busy", i),      busy_cnt,            vecs[i].exp_busy);
      check($sformatf("vec%0d_quotient", i),  bus.Quotient,        vecs[i].exp_q);
      check($sformatf("vec%0d_remainder", i), bus.Remainder,       vecs[i].exp_r);
      check($sformatf("vec%0d_dbz", i),       bus.Div_By_Zero,     vecs[i].exp_dbz);
      tick();
      check($sformatf("vec%0d_done_single", i), bus.Done,          0);
      check($sformatf("vec%0d_hold_q", i),      bus.Quotient,      vecs[i].exp_q);
      tick();
    end

    // A second Start while the first division is in RUN must be ignored.
    bus.Start = 1'b1; bus.Dividend = 4'd12; bus.Divisor = 4'd5;
    tick();
    bus.Start = 1'b0;
    tick();
    bus.Start = 1'b1; bus.Dividend = 4'd9; bus.Divisor = 4'd2;
    tick();
    bus.Start = 1'b0;
    done_cnt = 0; cap_q = '0; cap_r = '0;
    for (int c = 0; c < 12; c++) begin
      if (bus.Done) begin
        done_cnt++;
        cap_q = bus.Quotient;
        cap_r = bus.Remainder;
      end
      tick();
    end
    check("ignore_done_count", done_cnt, 1);
    check("ignore_quotient",   cap_q,    2);
    check("ignore_remainder",  cap_r,    2);

    // A reset on the second RUN cycle aborts the operation with no Done.
    bus.Start = 1'b1; bus.Dividend = 4'd14; bus.Divisor = 4'd4;
    tick();
    bus.Start = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("abort_quotient",  bus.Quotient,    0);
    check("abort_remainder", bus.Remainder,   0);
    check("abort_busy",      bus.Busy,        0);
    check("abort_done",      bus.Done,        0);
    check("abort_dbz",       bus.Div_By_Zero, 0);
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.Done) done_cnt++;
      tick();
    end
    check("abort_no_done", done_cnt, 0);
    run_div(4'd14, 4'd4, lat, busy_cnt);
    check("after_abort_latency",   lat,           W);
    check("after_abort_quotient",  bus.Quotient,  3);
    check("after_abort_remainder", bus.Remainder, 2);
    tick();
    tick();

    // Reset has priority over a Start in the same cycle.
    Rst = 1'b1; bus.Start = 1'b1; bus.Dividend = 4'd9; bus.Divisor = 4'd2;
    tick();
    Rst = 1'b0; bus.Start = 1'b0;
    check("rst_priority_busy", bus.Busy, 0);
    check("rst_priority_done", bus.Done, 0);
    tick();

    // Hold Start high and sweep every operand pair. The results must come back
    // to back: the gap is DONE + IDLE + the run length.
    bus.Start = 1'b1;
    first = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        bus.Dividend = W'(a);
        bus.Divisor  = W'(b);
        gap = 0;
        do begin
          tick();
          gap++;
        end while (!bus.Done && gap < 20);
        if (!first)
          check($sformatf("sweep_%0d_%0d_gap", a, b), gap, (b != 0) ? W + 2 : 2);
        first = 1'b0;
        check($sformatf("sweep_%0d_%0d_done", a, b), bus.Done, 1);
        check($sformatf("sweep_%0d_%0d_quotient", a, b), bus.Quotient,
              (b == 0) ? 32'd15 : 32'(a / b));
        check($sformatf("sweep_%0d_%0d_remainder", a, b), bus.Remainder,
              (b == 0) ? 32'(a) : 32'(a % b));
        check($sformatf("sweep_%0d_%0d_dbz", a, b), bus.Div_By_Zero, (b == 0) ? 1 : 0);
      end
    end
    bus.Start = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
